// File: rtl/data_mem_line_responder_if.sv
// rtl/data_mem_line_responder_if.sv - request, write-back and refill signals between L1 data cache and line responder
interface data_mem_line_responder_if;
  // request channel
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_wr_i;
  logic [31:0] req_addr_i;

  // write-back beat channel
  logic        wr_valid_i;
  logic [31:0] wr_data_i;
  logic [3:0]  wr_byte_en_i;
  logic        wr_ready_o;
  logic        wr_done_o;

  // refill beat channel (no backpressure)
  logic        rd_valid_o;
  logic [31:0] rd_data_o;
  logic        rd_last_o;

  // responder side
  modport slave (
    input  req_valid_i, req_wr_i, req_addr_i,
    input  wr_valid_i, wr_data_i, wr_byte_en_i,
    output req_ready_o, wr_ready_o, wr_done_o,
    output rd_valid_o, rd_data_o, rd_last_o
  );

  // cache side
  modport master (
    output req_valid_i, req_wr_i, req_addr_i,
    output wr_valid_i, wr_data_i, wr_byte_en_i,
    input  req_ready_o, wr_ready_o, wr_done_o,
    input  rd_valid_o, rd_data_o, rd_last_o
  );
endinterface

// File: rtl/data_mem_line_responder.sv
// rtl/data_mem_line_responder.sv - backing word array servicing line refills and write-backs with latency and bursts
module data_mem_line_responder #(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned LINE_WORDS = 4,
  parameter int unsigned LATENCY    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  data_mem_line_responder_if.slave bus
);

  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
  localparam int unsigned BEAT_W = $clog2(LINE_WORDS);
  localparam int unsigned LINE_W = IDX_W - BEAT_W;
  localparam int unsigned LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT     = 2'd1,
    S_RD_BURST = 2'd2,
    S_WR_BURST = 2'd3
  } state_e;

  // Backing store; never reset so contents survive a reset.
  logic [31:0] mem_q [MEM_WORDS];

  state_e              state_q,    state_d;
  logic [LAT_W-1:0]    lat_q,      lat_d;
  logic [BEAT_W-1:0]   beat_q,     beat_d;
  logic [LINE_W-1:0]   line_q,     line_d;
  logic                is_wr_q,    is_wr_d;
  logic                rd_valid_q, rd_valid_d;
  logic                rd_last_q,  rd_last_d;
  logic [31:0]         rd_data_q,  rd_data_d;
  logic                wr_done_q,  wr_done_d;

  logic                accept;
  logic                wr_fire;
  logic                last_beat;
  logic [LINE_W-1:0]   req_line;
  logic [IDX_W-1:0]    wr_idx;
  logic                addr_unused;

  // The line number is the word index with the in-line offset dropped;
  // byte offset, word offset and bits above the array depth are ignored.
  assign req_line    = bus.req_addr_i[IDX_W+1:BEAT_W+2];
  assign addr_unused = ^{bus.req_addr_i[31:IDX_W+2], bus.req_addr_i[BEAT_W+1:0]};

  assign accept    = bus.req_valid_i && (state_q == S_IDLE);
  assign wr_fire   = bus.wr_valid_i && (state_q == S_WR_BURST);
  assign last_beat = (beat_q == LAST_BEAT);
  // Lines are aligned, so concatenating the beat gives (base + beat) mod depth.
  assign wr_idx    = {line_q, beat_q};

  // State and registered outputs; reset aborts any burst in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      lat_q      <= '0;
      beat_q     <= '0;
      line_q     <= '0;
      is_wr_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
      wr_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      beat_q     <= beat_d;
      line_q     <= line_d;
      is_wr_q    <= is_wr_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
      wr_done_q  <= wr_done_d;
    end
  end

  // Next state: WAIT lasts LATENCY cycles so the first beat lands LATENCY cycles after acceptance.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    beat_d  = beat_q;
    line_d  = line_q;
    is_wr_d = is_wr_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_WAIT;
          lat_d   = LAT_LOAD;
          beat_d  = '0;
          line_d  = req_line;
          is_wr_d = bus.req_wr_i;
        end
      end
      S_WAIT: begin
        if (lat_q == '0) begin
          state_d = is_wr_q ? S_WR_BURST : S_RD_BURST;
        end else begin
          lat_d = lat_q - 1'b1;
        end
      end
      S_RD_BURST: begin
        if (last_beat) begin
          state_d = S_IDLE;
          beat_d  = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      S_WR_BURST: begin
        if (wr_fire) begin
          if (last_beat) begin
            state_d = S_IDLE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output values for the next cycle: the refill beat tracks the burst state being entered.
  always_comb begin
    rd_valid_d = (state_d == S_RD_BURST);
    rd_last_d  = rd_valid_d && (beat_d == LAST_BEAT);
    rd_data_d  = '0;
    if (rd_valid_d) begin
      rd_data_d = mem_q[{line_q, beat_d}];
    end
    wr_done_d  = wr_fire && last_beat;
  end

  // Byte-masked write of each accepted write-back beat; a reset edge writes nothing.
  always_ff @(posedge clk) begin
    if (!rst && wr_fire) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wr_byte_en_i[b]) begin
          mem_q[wr_idx][8*b +: 8] <= bus.wr_data_i[8*b +: 8];
        end
      end
    end
  end

  assign bus.req_ready_o = (state_q == S_IDLE);
  assign bus.wr_ready_o  = (state_q == S_WR_BURST);
  assign bus.wr_done_o   = wr_done_q;
  assign bus.rd_valid_o  = rd_valid_q;
  assign bus.rd_last_o   = rd_last_q;
  assign bus.rd_data_o   = rd_data_q;

endmodule

// File: tb/tb_data_mem_line_responder.sv
// tb/tb_data_mem_line_responder.sv - self-checking bench for data_mem_line_responder
module tb_data_mem_line_responder;

  localparam int MW  = 1024;
  localparam int LW  = 4;
  localparam int LAT = 3;
  localparam int NV  = 13;

  typedef struct packed {
    logic            wr;
    logic [31:0]     addr;
    logic [3:0][31:0] words;
    logic [3:0]      be;
    logic [7:0]      gap_after;
    logic [7:0]      gap_len;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_line_responder_if bus();

  data_mem_line_responder #(
    .MEM_WORDS (MW),
    .LINE_WORDS(LW),
    .LATENCY   (LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_mem [MW];
  vec_t        vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int widx(input logic [31:0] addr, input int i);
    int base;
    base = int'(addr[31:2]) & ~(LW - 1);
    return (base + i) & (MW - 1);
  endfunction

  function automatic vec_t mkv(input logic wr, input logic [31:0] addr,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] d3,
                               input logic [3:0] be, input logic [7:0] ga, input logic [7:0] gl);
    vec_t v;
    v.wr        = wr;
    v.addr      = addr;
    v.words     = {d3, d2, d1, d0};
    v.be        = be;
    v.gap_after = ga;
    v.gap_len   = gl;
    return v;
  endfunction

  task automatic send_req(input logic wr, input logic [31:0] addr, output bit ok);
    bit rdy;
    ok = 1'b0;
    bus.req_valid_i = 1'b1;
    bus.req_wr_i    = wr;
    bus.req_addr_i  = addr;
    for (int c = 0; c < 20; c++) begin
      rdy = bus.req_ready_o;
      tick();
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    bus.req_valid_i = 1'b0;
    bus.req_wr_i    = $urandom_range(0, 1);
    bus.req_addr_i  = $urandom;
    if (!ok) check("req_accept_timeout", 64'd0, 64'd1);
  endtask

  // Refill: beat i must be visible in cycle LAT+i after acceptance, idle again right after the last beat.
  task automatic do_read(input logic [31:0] addr, input logic [3:0][31:0] exp);
    bit          ok;
    bit          ev;
    logic [31:0] ed;
    send_req(1'b0, addr, ok);
    if (!ok) return;
    for (int k = 0; k <= LAT + LW; k++) begin
      ev = (k >= LAT) && (k < LAT + LW);
      ed = 32'd0;
      if (ev) ed = exp[k - LAT];
      check("rd_beat",
            {29'd0, bus.rd_valid_o, bus.rd_last_o, bus.req_ready_o, bus.rd_data_o},
            {29'd0, ev, (k == LAT + LW - 1), (k == LAT + LW), ed});
      if (k < LAT + LW) tick();
    end
  endtask

  task automatic do_read_model(input logic [31:0] addr);
    logic [3:0][31:0] exp;
    for (int i = 0; i < LW; i++) exp[i] = model_mem[widx(addr, i)];
    do_read(addr, exp);
  endtask

  // Write-back: junk is offered during WAIT and gaps; only beats taken while ready may land.
  task automatic do_write(input logic [31:0] addr, input logic [3:0][31:0] words,
                          input logic [3:0] be, input int gap_after, input int gap_len,
                          input int rst_after);
    bit ok;
    bit done;
    bit exp_rdy;
    bit fire;
    int b;
    int gap_left;
    int wi;
    send_req(1'b1, addr, ok);
    if (!ok) return;
    b        = 0;
    gap_left = 0;
    done     = 1'b0;
    for (int k = 0; k < 80; k++) begin
      exp_rdy = (k >= LAT) && (b < LW);
      check("wr_state",
            {61'd0, bus.wr_ready_o, bus.wr_done_o, bus.req_ready_o},
            {61'd0, exp_rdy, (b == LW), (b == LW)});
      if (b == LW) begin
        done = 1'b1;
        break;
      end
      if (rst_after >= 0 && b == rst_after) begin
        rst                = 1'b1;
        bus.wr_valid_i     = 1'b1;
        bus.wr_data_i      = words[b];
        bus.wr_byte_en_i   = be;
        tick();
        rst                = 1'b0;
        bus.wr_valid_i     = 1'b0;
        check("reset_abort",
              64'({bus.wr_ready_o, bus.wr_done_o, bus.rd_valid_o, bus.rd_last_o, bus.req_ready_o, bus.rd_data_o}),
              64'({5'b00001, 32'd0}));
        return;
      end
      if (k < LAT) begin
        bus.wr_valid_i   = 1'b1;
        bus.wr_data_i    = $urandom;
        bus.wr_byte_en_i = 4'hF;
      end else if (gap_left > 0) begin
        bus.wr_valid_i   = 1'b0;
        bus.wr_data_i    = $urandom;
        bus.wr_byte_en_i = 4'hF;
        gap_left--;
      end else begin
        bus.wr_valid_i   = 1'b1;
        bus.wr_data_i    = words[b];
        bus.wr_byte_en_i = be;
      end
      fire = bus.wr_valid_i && exp_rdy;
      tick();
      if (fire) begin
        wi = widx(addr, b);
        for (int j = 0; j < 4; j++) begin
          if (be[j]) model_mem[wi][8*j +: 8] = words[b][8*j +: 8];
        end
        if (b == gap_after) gap_left = gap_len;
        b++;
      end
    end
    bus.wr_valid_i = 1'b0;
    if (!done) check("wr_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [3:0][31:0] w;
    logic [3:0][31:0] e;
    logic [31:0]      old2;
    logic [31:0]      old3;

    vecs[0]  = mkv(1'b1, 32'h0000_0040, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 4'hF, 8'hFF, 8'd0);
    vecs[1]  = mkv(1'b0, 32'h0000_0040, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 4'h0, 8'hFF, 8'd0);
    vecs[2]  = mkv(1'b1, 32'h0000_0040, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 4'hF, 8'hFF, 8'd0);
    vecs[3]  = mkv(1'b0, 32'h0000_004C, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 4'h0, 8'hFF, 8'd0);
    vecs[4]  = mkv(1'b0, 32'h0000_0044, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 4'h0, 8'hFF, 8'd0);
    vecs[5]  = mkv(1'b1, 32'h0000_0080, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 4'hF, 8'hFF, 8'd0);
    vecs[6]  = mkv(1'b1, 32'h0000_0080, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 4'h3, 8'hFF, 8'd0);
    vecs[7]  = mkv(1'b0, 32'h0000_0080, 32'h1234_BEEF, 32'h1234_BEEF, 32'h1234_BEEF, 32'h1234_BEEF, 4'h0, 8'hFF, 8'd0);
    vecs[8]  = mkv(1'b1, 32'h0000_1FF0, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 4'hF, 8'hFF, 8'd0);
    vecs[9]  = mkv(1'b0, 32'h0000_0FF0, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 4'h0, 8'hFF, 8'd0);
    vecs[10] = mkv(1'b0, 32'h0000_1FF0, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 4'h0, 8'hFF, 8'd0);
    vecs[11] = mkv(1'b1, 32'h0000_0100, 32'h5500_0000, 32'h5500_0001, 32'h5500_0002, 32'h5500_0003, 4'hF, 8'd1, 8'd5);
    vecs[12] = mkv(1'b0, 32'h0000_0100, 32'h5500_0000, 32'h5500_0001, 32'h5500_0002, 32'h5500_0003, 4'h0, 8'hFF, 8'd0);

    bus.req_valid_i  = 1'b0;
    bus.req_wr_i     = 1'b0;
    bus.req_addr_i   = 32'd0;
    bus.wr_valid_i   = 1'b0;
    bus.wr_data_i    = 32'd0;
    bus.wr_byte_en_i = 4'h0;

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("reset_state",
          64'({bus.wr_ready_o, bus.wr_done_o, bus.rd_valid_o, bus.rd_last_o, bus.req_ready_o, bus.rd_data_o}),
          64'({5'b00001, 32'd0}));

    // Give every word a known value so random refills have a defined expectation.
    for (int line = 0; line < MW / LW; line++) begin
      for (int j = 0; j < LW; j++) w[j] = $urandom;
      do_write(32'(line * LW * 4), w, 4'hF, -1, 0, -1);
    end

    for (int i = 0; i < NV; i++) begin
      if (vecs[i].wr) begin
        do_write(vecs[i].addr, vecs[i].words, vecs[i].be,
                 (vecs[i].gap_after == 8'hFF) ? -1 : int'(vecs[i].gap_after),
                 int'(vecs[i].gap_len), -1);
      end else begin
        do_read(vecs[i].addr, vecs[i].words);
      end
    end

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = $urandom & 32'h0000_FFFF;
      if ($urandom_range(0, 1) == 1) begin
        for (int j = 0; j < LW; j++) w[j] = $urandom;
        do_write(a, w, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 4), -1);
      end else begin
        do_read_model(a);
      end
    end

    // Reset after beat 1: beats 0..1 persist, beats 2..3 keep their old contents.
    old2 = model_mem[2];
    old3 = model_mem[3];
    w    = {32'hF00D_0003, 32'hF00D_0002, 32'hF00D_0001, 32'hF00D_0000};
    do_write(32'h0000_0000, w, 4'hF, -1, 0, 2);
    e    = {old3, old2, 32'hF00D_0001, 32'hF00D_0000};
    do_read(32'h0000_0000, e);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
